// File: rtl/paddle_input_arbiter.sv
// Purpose : per-paddle arbitration of PS/2, UART and button commands into clean up/down levels.
// Latency : 1 cycle to grant, 1 cycle from granted level to pad_up/pad_dn, any_press 1 cycle after the pad edge.
// Backpress: none; all inputs are levels or pulses sampled every cycle, and nothing is ever stalled.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   frame_tick           one-cycle pulse per video frame; paces the hold and idle counters
//   ps2_up/ps2_dn        PS/2 keyboard levels, bit p = paddle p
//   uart_up/uart_dn      UART key commands, one-cycle pulses, stretched internally
//   btn_up/btn_dn        debounced board button levels
//   pad_up/pad_dn        registered, arbitrated paddle levels
//   owner                [2p+1:2p] owner of paddle p: 0 none, 1 PS2, 2 UART, 3 BTN
//   any_press            one-cycle pulse after any pad_up/pad_dn bit rises
//
// Build option: define PADDLE_PREEMPT_EN to let a strictly higher-priority source take an
// owned paddle immediately. Without it the owner keeps the paddle until the idle timeout.
// Parameter constraint: LOCK_TICKS < 2**CW.

module paddle_input_arbiter #(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned LOCK_TICKS = 120,
  parameter int unsigned CW         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [1:0] ps2_up,
  input  logic [1:0] ps2_dn,
  input  logic [1:0] uart_up,
  input  logic [1:0] uart_dn,
  input  logic [1:0] btn_up,
  input  logic [1:0] btn_dn,
  output logic [1:0] pad_up,
  output logic [1:0] pad_dn,
  output logic [3:0] owner,
  output logic       any_press
);

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Source codes double as priority: a smaller non-zero code wins.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_PS2  = 2'd1;
  localparam logic [1:0] SRC_UART = 2'd2;
  localparam logic [1:0] SRC_BTN  = 2'd3;

  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_TICKS);

  genvar p;
  for (p = 0; p < 2; p++) begin : g_pad

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          dir_up_q, dir_up_d;
    logic          pad_up_q, pad_up_d;
    logic          pad_dn_q, pad_dn_d;

    logic          uart_up_lvl, uart_dn_lvl;
    logic          act_ps2, act_uart, act_btn;
    logic [3:0]    src_up, src_dn;
    logic [1:0]    grant;
    logic          own_up, own_dn, own_act;
    logic          preempt;

    // UART stretch: a pulse latches its direction and (re)loads the hold counter.
    // Up wins when both pulses land together.
    always_comb begin
      dir_up_d = dir_up_q;
      hold_d   = hold_q;
      if (uart_up[p] || uart_dn[p]) begin
        dir_up_d = uart_up[p];
        hold_d   = HOLD_CNT;
      end else if (frame_tick && (hold_q != '0)) begin
        hold_d = hold_q - CW'(1);
      end
    end

    assign uart_up_lvl = (hold_q != '0) &&  dir_up_q;
    assign uart_dn_lvl = (hold_q != '0) && !dir_up_q;

    // Bit index equals the source code; bit 0 (no owner) is never active.
    assign src_up = {btn_up[p], uart_up_lvl, ps2_up[p], 1'b0};
    assign src_dn = {btn_dn[p], uart_dn_lvl, ps2_dn[p], 1'b0};

    assign act_ps2  = ps2_up[p] | ps2_dn[p];
    assign act_uart = uart_up_lvl | uart_dn_lvl;
    assign act_btn  = btn_up[p] | btn_dn[p];

    always_comb begin
      grant = SRC_NONE;
      if (act_ps2) begin
        grant = SRC_PS2;
      end else if (act_uart) begin
        grant = SRC_UART;
      end else if (act_btn) begin
        grant = SRC_BTN;
      end
    end

    assign own_up  = src_up[owner_q];
    assign own_dn  = src_dn[owner_q];
    assign own_act = own_up | own_dn;

`ifdef PADDLE_PREEMPT_EN
    assign preempt = (grant != SRC_NONE) && (grant < owner_q);
`else
    assign preempt = 1'b0;
`endif

    // Ownership FSM. The release cycle only clears the owner; the waiting source is
    // granted by the FREE branch on the following cycle.
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      idle_d  = idle_q;
      if (state_q == FREE) begin
        if (grant != SRC_NONE) begin
          state_d = OWNED;
          owner_d = grant;
          idle_d  = '0;
        end
      end else begin
        if (preempt) begin
          owner_d = grant;
          idle_d  = '0;
        end else if (idle_q == LOCK_CNT) begin
          state_d = FREE;
          owner_d = SRC_NONE;
          idle_d  = '0;
        end else if (own_act) begin
          idle_d = '0;
        end else if (frame_tick && (idle_q < LOCK_CNT)) begin
          idle_d = idle_q + CW'(1);
        end
      end
    end

    // Only the owner reaches the pins; up and down together cancel out.
    always_comb begin
      pad_up_d = (state_q == OWNED) && own_up && !own_dn;
      pad_dn_d = (state_q == OWNED) && own_dn && !own_up;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= FREE;
        owner_q  <= SRC_NONE;
        hold_q   <= '0;
        idle_q   <= '0;
        dir_up_q <= 1'b0;
        pad_up_q <= 1'b0;
        pad_dn_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        owner_q  <= owner_d;
        hold_q   <= hold_d;
        idle_q   <= idle_d;
        dir_up_q <= dir_up_d;
        pad_up_q <= pad_up_d;
        pad_dn_q <= pad_dn_d;
      end
    end

  end : g_pad

  assign pad_up = {g_pad[1].pad_up_q, g_pad[0].pad_up_q};
  assign pad_dn = {g_pad[1].pad_dn_q, g_pad[0].pad_dn_q};
  assign owner  = {g_pad[1].owner_q,  g_pad[0].owner_q};

  // Edge detect on the registered pad levels; several bits rising together give one pulse.
  logic [1:0] pad_up_prev_q, pad_up_prev_d;
  logic [1:0] pad_dn_prev_q, pad_dn_prev_d;
  logic       any_press_q, any_press_d;

  always_comb begin
    pad_up_prev_d = pad_up;
    pad_dn_prev_d = pad_dn;
    any_press_d   = |((pad_up & ~pad_up_prev_q) | (pad_dn & ~pad_dn_prev_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_up_prev_q <= '0;
      pad_dn_prev_q <= '0;
      any_press_q   <= 1'b0;
    end else begin
      pad_up_prev_q <= pad_up_prev_d;
      pad_dn_prev_q <= pad_dn_prev_d;
      any_press_q   <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_paddle_input_arbiter.sv
// Purpose : directed, table-driven checks of paddle_input_arbiter with default parameters.
// Latency : inputs change on the falling edge, outputs are sampled on a later falling edge.
// Backpress: not applicable.

module tb_paddle_input_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] ps2_up = '0, ps2_dn = '0;
  logic [1:0] uart_up = '0, uart_dn = '0;
  logic [1:0] btn_up = '0, btn_dn = '0;
  logic [1:0] pad_up, pad_dn;
  logic [3:0] owner;
  logic       any_press;

  int n_pass  = 0;
  int n_total = 0;

  paddle_input_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .ps2_up     (ps2_up),
    .ps2_dn     (ps2_dn),
    .uart_up    (uart_up),
    .uart_dn    (uart_dn),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .pad_up     (pad_up),
    .pad_dn     (pad_dn),
    .owner      (owner),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [1:0] ps2_up, ps2_dn, uart_up, uart_dn, btn_up, btn_dn;
    logic       ft;
    logic [1:0] e_up, e_dn;
    logic [3:0] e_own;
    logic       e_ap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs;
    frame_tick = 1'b0;
    ps2_up = '0; ps2_dn = '0; uart_up = '0; uart_dn = '0; btn_up = '0; btn_dn = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  // One frame tick: one cycle with frame_tick high, then one quiet cycle.
  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  function automatic void add(bit rst, logic [1:0] pu, logic [1:0] pd, logic [1:0] uu,
                              logic [1:0] ud, logic [1:0] bu, logic [1:0] bd, logic ft,
                              logic [1:0] eu, logic [1:0] ed, logic [3:0] eo, logic ea);
    vec_t v;
    v.rst = rst; v.ps2_up = pu; v.ps2_dn = pd; v.uart_up = uu; v.uart_dn = ud;
    v.btn_up = bu; v.btn_dn = bd; v.ft = ft;
    v.e_up = eu; v.e_dn = ed; v.e_own = eo; v.e_ap = ea;
    vecs.push_back(v);
  endfunction

  initial begin
    // Conflict suppression and any_press on button-owned paddles.
    //  rst ps2u  ps2d  uu    ud    btnu  btnd  ft    eup   edn   eown     eap
    add(1, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b00,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b01,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b01,2'b00,4'b0011,1'b1);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b01,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,1'b0, 2'b00,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,1'b0, 2'b00,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b01,2'b00,4'b0011,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0, 2'b01,2'b00,4'b0011,1'b1);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b00,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b1);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b00,2'b00,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b00,2'b00,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b1);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,1'b0, 2'b01,2'b10,4'b1111,1'b0);
    // Simultaneous UART pulses: up wins, then a down pulse flips and reloads.
    add(1, 2'b00,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0, 2'b00,2'b00,4'b0000,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b00,2'b00,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b01,2'b00,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 2'b01,2'b00,4'b0010,1'b1);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 2'b01,2'b00,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 2'b01,2'b00,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b01,2'b00,2'b00,1'b0, 2'b01,2'b00,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b00,2'b01,4'b0010,1'b0);
    add(0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 2'b00,2'b01,4'b0010,1'b1);

    // ---- Reset with every source active, then release ----
    ps2_up = 2'b11; uart_up = 2'b11; btn_up = 2'b11; btn_dn = 2'b11;
    step(3);
    chk("rst_pad_up", {30'b0, pad_up}, 32'd0);
    chk("rst_pad_dn", {30'b0, pad_dn}, 32'd0);
    chk("rst_owner", {28'b0, owner}, 32'd0);
    chk("rst_any_press", {31'b0, any_press}, 32'd0);
    reset_n = 1'b1;
    uart_up = 2'b00;
    step(1);
    chk("rel_owner_ps2", {28'b0, owner}, 32'h5);
    chk("rel_pad_up_c1", {30'b0, pad_up}, 32'd0);
    step(1);
    chk("rel_pad_up_c2", {30'b0, pad_up}, 32'h3);
    step(1);
    chk("rel_any_press", {31'b0, any_press}, 32'd1);
    step(1);
    chk("rel_any_press_end", {31'b0, any_press}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_owner", {28'b0, owner}, 32'd0);
    chk("async_rst_pad_up", {30'b0, pad_up}, 32'd0);

    // ---- UART stretch on paddle 1 ----
    do_reset();
    uart_up = 2'b10;
    step(1);
    uart_up = 2'b00;
    chk("uart_no_grant_yet", {28'b0, owner}, 32'd0);
    step(1);
    chk("uart_owner", {30'b0, owner[3:2]}, 32'd2);
    step(1);
    chk("uart_pad_up", {31'b0, pad_up[1]}, 32'd1);
    tick(7);
    chk("uart_held_7", {31'b0, pad_up[1]}, 32'd1);
    tick(1);
    chk("uart_drop_8", {31'b0, pad_up[1]}, 32'd0);
    chk("uart_owner_kept", {30'b0, owner[3:2]}, 32'd2);
    tick(119);
    chk("uart_owner_119", {30'b0, owner[3:2]}, 32'd2);
    chk("uart_pad0_free", {30'b0, owner[1:0]}, 32'd0);
    tick(1);
    chk("uart_released", {30'b0, owner[3:2]}, 32'd0);

`ifdef PADDLE_PREEMPT_EN
    // ---- Preemption of a button owner by PS/2 ----
    do_reset();
    btn_up = 2'b01;
    step(2);
    chk("pre_btn_owner", {30'b0, owner[1:0]}, 32'd3);
    chk("pre_btn_pad", {31'b0, pad_up[0]}, 32'd1);
    ps2_up = 2'b01;
    step(1);
    chk("pre_ps2_owner", {30'b0, owner[1:0]}, 32'd1);
    ps2_up = 2'b00;
    step(1);
    chk("pre_follow_ps2", {31'b0, pad_up[0]}, 32'd0);
    ps2_dn = 2'b01;
    step(1);
    chk("pre_ps2_dn", {31'b0, pad_dn[0]}, 32'd1);
    chk("pre_owner_kept", {30'b0, owner[1:0]}, 32'd1);
`else
    // ---- Lockout: PS/2 waits until the idle button owner times out ----
    do_reset();
    btn_up = 2'b01;
    step(2);
    chk("lock_btn_owner", {30'b0, owner[1:0]}, 32'd3);
    chk("lock_btn_pad", {31'b0, pad_up[0]}, 32'd1);
    btn_up = 2'b00;
    ps2_dn = 2'b01;
    step(1);
    chk("lock_ps2_ignored", {30'b0, pad_up[0], pad_dn[0]}, 32'd0);
    tick(119);
    chk("lock_owner_119", {30'b0, owner[1:0]}, 32'd3);
    chk("lock_pad_dn_119", {31'b0, pad_dn[0]}, 32'd0);
    tick(1);
    chk("lock_released", {30'b0, owner[1:0]}, 32'd0);
    step(1);
    chk("lock_regrant_ps2", {30'b0, owner[1:0]}, 32'd1);
    step(1);
    chk("lock_pad_dn", {31'b0, pad_dn[0]}, 32'd1);
`endif

    // ---- Table-driven vectors ----
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      ps2_up = vecs[i].ps2_up; ps2_dn = vecs[i].ps2_dn;
      uart_up = vecs[i].uart_up; uart_dn = vecs[i].uart_dn;
      btn_up = vecs[i].btn_up; btn_dn = vecs[i].btn_dn;
      frame_tick = vecs[i].ft;
      step(1);
      chk($sformatf("vec%0d", i), {23'b0, pad_up, pad_dn, owner, any_press},
          {23'b0, vecs[i].e_up, vecs[i].e_dn, vecs[i].e_own, vecs[i].e_ap});
    end
    clear_inputs();

    // The down pulse reloaded the hold counter to 8 after 3 ticks had elapsed.
    tick(7);
    chk("reload_held_7", {31'b0, pad_dn[0]}, 32'd1);
    tick(1);
    chk("reload_drop_8", {31'b0, pad_dn[0]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
